uart_receiver: RTL

Serial-to-parallel UART receive stage; the far-end counterpart of the team's UART transmitter, consuming its `tx` line. Frame format matches the transmitter: 1 start bit (0), WORD_SIZE data bits MSB first, 1 stop bit (1), no parity. It mid-bit samples the synchronized line and presents each good word in a holding register with a valid/ack handshake. It also flags framing errors and overruns.

---
 rtl/uart_receiver.sv | 135 +++++++++++++
 1 files changed

// File: rtl/uart_receiver.sv
// UART receive stage: 1 start bit, WORD_SIZE data bits MSB first, 1 stop bit, no parity.
// Mid-bit samples the synchronized line and holds each good word behind a valid/ack handshake.
module uart_receiver #(
   parameter int unsigned WORD_SIZE  = 8,
   parameter int unsigned CLOCK_FREQ = 1_000_000,
   parameter int unsigned BAUD_RATE  = 100_000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic [WORD_SIZE-1:0] data_recv,
   output logic                 rx_valid_o,
   input  logic                 rx_ack_i,
   output logic                 overrun_o,
   output logic                 frame_err_o
);

   localparam int unsigned BAUD_LIMIT = CLOCK_FREQ / BAUD_RATE;
   localparam int unsigned HALF       = BAUD_LIMIT / 2;
   localparam int unsigned CNT_W      = 16;
   localparam int unsigned BIT_W      = $clog2(WORD_SIZE);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t               state, state_n;
   logic                 rx_meta, rx_s, rx_prev;
   logic [CNT_W-1:0]     cnt, cnt_n;
   logic [BIT_W-1:0]     bit_cnt, bit_cnt_n;
   logic [WORD_SIZE-1:0] shift, shift_n;
   logic [WORD_SIZE-1:0] data_n;
   logic                 valid_n, ovr_n, ferr_n;

   // Two-flop synchronizer plus one-cycle delayed copy for falling-edge detection
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
         rx_prev <= rx_s;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         bit_cnt     <= '0;
         shift       <= '0;
         data_recv   <= '0;
         rx_valid_o  <= 1'b0;
         overrun_o   <= 1'b0;
         frame_err_o <= 1'b0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         bit_cnt     <= bit_cnt_n;
         shift       <= shift_n;
         data_recv   <= data_n;
         rx_valid_o  <= valid_n;
         overrun_o   <= ovr_n;
         frame_err_o <= ferr_n;
      end
   end

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      bit_cnt_n = bit_cnt;
      shift_n   = shift;
      data_n    = data_recv;
      valid_n   = rx_valid_o;
      ovr_n     = overrun_o;
      ferr_n    = 1'b0;

      // Consumer ack; a word load later in this block takes precedence over it
      if (rx_ack_i && rx_valid_o) begin
         valid_n = 1'b0;
         ovr_n   = 1'b0;
      end

      case (state)
         IDLE: begin
            if (rx_prev && !rx_s) begin
               cnt_n   = '0;
               state_n = START;
            end
         end
         START: begin
            cnt_n = cnt + CNT_W'(1);
            if (cnt == CNT_W'(HALF - 1)) begin
               if (!rx_s) begin
                  cnt_n     = '0;
                  bit_cnt_n = '0;
                  state_n   = DATA;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         DATA: begin
            cnt_n = cnt + CNT_W'(1);
            if (cnt == CNT_W'(BAUD_LIMIT - 1)) begin
               cnt_n   = '0;
               shift_n = {shift[WORD_SIZE-2:0], rx_s};
               if (bit_cnt == BIT_W'(WORD_SIZE - 1)) begin
                  state_n = STOP;
               end else begin
                  bit_cnt_n = bit_cnt + BIT_W'(1);
               end
            end
         end
         STOP: begin
            cnt_n = cnt + CNT_W'(1);
            if (cnt == CNT_W'(BAUD_LIMIT - 1)) begin
               cnt_n   = '0;
               state_n = IDLE;
               if (rx_s) begin
                  data_n  = shift;
                  valid_n = 1'b1;
                  if (rx_valid_o && !rx_ack_i) begin
                     ovr_n = 1'b1;
                  end
               end else begin
                  ferr_n = 1'b1;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule
